// File: rtl/conv_pkg.sv
// Shared code definition for the rate-1/2, K=3 convolutional link (encoder and decoder).
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENC,
    ST_DONE
  } state_t;

  localparam int MAX_BITS    = 7;
  localparam int SIZE_OFFSET = 3;
  localparam int MAX_SIZE    = 4;

  localparam logic [2:0] DEF_G0 = 3'b111;
  localparam logic [2:0] DEF_G1 = 3'b101;

endpackage

// File: rtl/conv_step.sv
// One trellis step: code pair for input bit u given register state (s1,s2); purely combinational.
// No state and no backpressure.
module conv_step #(
  parameter logic [2:0] G0 = 3'b111,
  parameter logic [2:0] G1 = 3'b101
) (
  input  logic u,
  input  logic s1,
  input  logic s2,
  output logic c0,
  output logic c1
);

  logic [2:0] taps;

  // Generator MSB taps the incoming bit, LSB the oldest register stage.
  assign taps = {u, s1, s2};
  assign c0   = ^(G0 & taps);
  assign c1   = ^(G1 & taps);

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 convolutional encoder; done pulses k cycles after the capture edge (0 for a bad size).
// No backpressure: enable, size and dstring are only sampled in IDLE.
module conv_encoder
  import conv_pkg::*;
#(
  parameter logic [2:0] G0 = DEF_G0,
  parameter logic [2:0] G1 = DEF_G1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [2:0]              size,
  input  logic [MAX_BITS-1:0]     dstring,
  output logic [2*MAX_BITS-1:0]   rstring,
  output logic                    done,
  output logic                    busy,
  output logic                    err
);

  state_t              state;
  state_t              state_nxt;
  logic [MAX_BITS-1:0] data_q;
  logic [2:0]          k_q;
  logic [2:0]          bit_cnt;
  logic                s1;
  logic                s2;
  logic                c0;
  logic                c1;
  logic                size_ok;
  logic                last_bit;
  logic [2:0]          shamt;

  assign size_ok  = (size <= 3'(MAX_SIZE));
  assign last_bit = (bit_cnt == (k_q - 3'd1));
  // Left-align the k used bits so the next bit to encode is always data_q MSB.
  assign shamt    = 3'(MAX_SIZE) - size;

  conv_step #(
    .G0 (G0),
    .G1 (G1)
  ) u_step (
    .u  (data_q[MAX_BITS-1]),
    .s1 (s1),
    .s2 (s2),
    .c0 (c0),
    .c1 (c1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt = size_ok ? ST_ENC : ST_DONE;
        end
      end
      ST_ENC: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      k_q     <= '0;
      bit_cnt <= '0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      rstring <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            data_q  <= size_ok ? (dstring << shamt) : '0;
            k_q     <= size + 3'(SIZE_OFFSET);
            bit_cnt <= '0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            rstring <= '0;
            err     <= ~size_ok;
          end
        end
        ST_ENC: begin
          // Pairs shift up from the bottom, so after k steps pair 0 sits at bits 2k-1:2k-2.
          rstring <= {rstring[2*MAX_BITS-3:0], c0, c1};
          data_q  <= data_q << 1;
          s2      <= s1;
          s1      <= data_q[MAX_BITS-1];
          bit_cnt <= bit_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed vectors plus randomized jobs against a bit-level model.
module tb_conv_encoder;
  import conv_pkg::*;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [2:0]  size;
  logic [6:0]  dstring;
  logic [13:0] rstring;
  logic        done;
  logic        busy;
  logic        err;

  int n_checks;
  int n_errors;

  conv_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .size    (size),
    .dstring (dstring),
    .rstring (rstring),
    .done    (done),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: walk the data bits MSB-first, computing each pair from the generators.
  function automatic logic [13:0] ref_enc(input logic [2:0] sz, input logic [6:0] d);
    logic [13:0] r;
    logic        s1, s2, u, c0, c1;
    int          k;
    r  = '0;
    s1 = 1'b0;
    s2 = 1'b0;
    if (sz > 3'd4) return r;
    k = int'(sz) + 3;
    for (int i = 0; i < k; i++) begin
      u  = d[k-1-i];
      c0 = ^(DEF_G0 & {u, s1, s2});
      c1 = ^(DEF_G1 & {u, s1, s2});
      r[2*k-1-2*i] = c0;
      r[2*k-2-2*i] = c1;
      s2 = s1;
      s1 = u;
    end
    return r;
  endfunction

  // Starts a job from an IDLE cycle and returns sampled in the DONE cycle.
  task automatic run_job(input logic [2:0] sz, input logic [6:0] d, input logic [13:0] exp_r,
                         input bit keep_en, input bit scramble);
    int lat;
    bit seen;
    enable  = 1'b1;
    size    = sz;
    dstring = d;
    @(posedge clk); #1;
    if (!keep_en) enable = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      if (done) begin
        seen = 1'b1;
        lat  = cyc;
      end else begin
        check("busy_enc", busy, 1);
        if (scramble) begin
          dstring = 7'($urandom);
          size    = 3'($urandom);
        end
      end
    end
    check("done_seen", seen, 1);
    check("latency", lat, (sz > 3'd4) ? 0 : int'(sz) + 3);
    check("busy_done", busy, 1);
    check("rstring", rstring, exp_r);
    check("err", err, sz > 3'd4);
  endtask

  task automatic idle_chk(input logic [13:0] exp_r, input logic exp_err);
    @(posedge clk); #1;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_rstring", rstring, exp_r);
    check("idle_err", err, exp_err);
  endtask

  initial begin
    logic [2:0]  sz;
    logic [6:0]  d;
    logic [2:0]  sz2;
    logic [6:0]  d2;
    bit          seen;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    enable   = 1'b0;
    size     = '0;
    dstring  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rstring", rstring, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_job(3'd1, 7'b0001011, 14'h00E1, 1'b0, 1'b0);
    idle_chk(14'h00E1, 1'b0);
    run_job(3'd2, 7'b0010110, 14'h0385, 1'b0, 1'b1);
    idle_chk(14'h0385, 1'b0);
    run_job(3'd4, 7'b0000000, 14'h0000, 1'b0, 1'b0);
    idle_chk(14'h0000, 1'b0);
    run_job(3'd0, 7'b0000001, 14'b00000000000011, 1'b0, 1'b0);
    idle_chk(14'b00000000000011, 1'b0);

    run_job(3'd6, 7'b1111111, 14'h0000, 1'b0, 1'b0);
    idle_chk(14'h0000, 1'b1);
    run_job(3'd3, 7'h5A, ref_enc(3'd3, 7'h5A), 1'b0, 1'b0);
    idle_chk(ref_enc(3'd3, 7'h5A), 1'b0);

    // Reset landing on the second ENC edge of a long job.
    enable  = 1'b1;
    size    = 3'd4;
    dstring = 7'h7F;
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_rstring", rstring, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("midrst_no_done", seen, 0);
    run_job(3'd2, 7'b0010110, 14'h0385, 1'b0, 1'b0);
    idle_chk(14'h0385, 1'b0);

    // Reset coinciding with a capture edge wins.
    enable = 1'b1;
    size   = 3'd2;
    rst    = 1'b1;
    @(posedge clk); #1;
    check("rstcap_busy", busy, 0);
    check("rstcap_rstring", rstring, 0);
    rst    = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;
    check("rstcap_idle", busy, 0);

    // Enable held across two jobs; inputs scrambled during the first.
    sz  = 3'd4;
    d   = 7'b1011001;
    sz2 = 3'd1;
    d2  = 7'b0110101;
    run_job(sz, d, ref_enc(sz, d), 1'b1, 1'b1);
    size    = sz2;
    dstring = d2;
    @(posedge clk); #1;
    check("gap_busy", busy, 0);
    check("gap_done", done, 0);
    check("gap_rstring", rstring, ref_enc(sz, d));
    run_job(sz2, d2, ref_enc(sz2, d2), 1'b0, 1'b0);
    idle_chk(ref_enc(sz2, d2), 1'b0);

    for (int j = 0; j < 30; j++) begin
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      d  = 7'($urandom);
      run_job(sz, d, ref_enc(sz, d), 1'b0, 1'($urandom));
      idle_chk(ref_enc(sz, d), sz > 3'd4);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 Parameter G0, default 3'b111, generator polynomial of the first (upper) code bit.
REQ-002 Parameter G1, default 3'b101, generator polynomial of the second (lower) code bit.
REQ-003 clk  input  1  the clock; all logic updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  start request; sampled only in IDLE.
REQ-006 size  input  3  data length code; k = size+3 data bits; valid codes 0..4 (k = 3..7).
REQ-007 dstring  input  7  data word; bits dstring[k-1:0] are used.
REQ-008 rstring  output  14  encoded word; pairs in rstring[2k-1:0], bits above 2k-1 zero.
REQ-009 done  output  1  one-cycle pulse: rstring valid (or err set).
REQ-010 busy  output  1  high in LOAD-accepted ENC and DONE states.
REQ-011 err  output  1  set when the accepted size code is 5..7; held until next start.

Function
REQ-012 Rate-1/2 convolutional encoder, constraint length 3, register (s1,s2) cleared at every start.
REQ-013 Per data bit u: c0 = parity(G0 & {u,s1,s2}); c1 = parity(G1 & {u,s1,s2}); then s2<=s1, s1<=u.
REQ-014 Defaults give c0 = u^s1^s2 and c1 = u^s2.
REQ-015 Bit order: dstring[k-1] encoded first, dstring[0] last.
REQ-016 Pair i (i=0 first) placed at rstring[2k-1-2i] = c0, rstring[2k-2-2i] = c1.
REQ-017 FSM states IDLE, ENC, DONE.
REQ-018 IDLE: on edge with enable=1, capture dstring and size, clear rstring, err, s1, s2 and bit counter; go to ENC (valid size) or DONE with err=1 (size 5..7).
REQ-019 ENC: one bit per edge; after the k-th bit edge, go to DONE.
REQ-020 DONE: done=1 for exactly one cycle; next edge returns to IDLE.
REQ-021 Latency: capture at edge N; done high during the cycle after edge N+k; for an invalid size, during the cycle after edge N.
REQ-022 enable, dstring and size ignored outside IDLE; changes during ENC do not affect the result.
REQ-023 enable held high continuously: a new start is accepted on the first IDLE edge after DONE, so one idle cycle separates jobs.
REQ-024 rstring and err hold their values from DONE until the next capture edge.
REQ-025 Invalid size: rstring stays 0 and no encoding cycles run.

Reset
REQ-026 rst=1 at a clock edge forces IDLE and clears rstring, done, busy, err, s1, s2, the bit counter and the captured registers.
REQ-027 rst has priority over every other condition, including a capture edge and mid-ENC.
REQ-028 A job interrupted by reset produces no done pulse.

Structure
REQ-029 Shared package conv_pkg holds the state enum, MAX_BITS=7, SIZE_OFFSET=3, MAX_SIZE=4 and the default generators.
REQ-030 The decoder imports conv_pkg so the two ends of the link share one code definition.
REQ-031 One combinational sub-module conv_step (inputs u, s1, s2; outputs c0, c1) computes one trellis step.
REQ-032 Top-level state, counter and output registers sit in conv_encoder.
REQ-033 Implementation target: 120-400 lines of RTL.

Verification
REQ-034 size=1, dstring=7'b0001011, enable pulse -> rstring=14'h00E1 (8'b11100001 in the low byte), done 4 cycles after capture, err=0.
REQ-035 size=2, dstring=7'b0010110 -> rstring=14'h0385 (10'b1110000101), done 5 cycles after capture.
REQ-036 size=4, dstring=7'b0000000 -> rstring=0, done 7 cycles after capture; then size=0, dstring=7'b0000001 -> rstring=14'b00000000000011.
REQ-037 size=6 -> done the cycle after capture, err=1, rstring=0; next valid job clears err.
REQ-038 rst asserted at the 2nd ENC edge -> IDLE next cycle, all outputs 0, no done pulse; a following job encodes correctly from a cleared state.
REQ-039 enable held high across two jobs, with dstring changed during ENC -> the first result reflects only the captured value; the second start comes one idle cycle after done.
